// File: rtl/dw_8b10b_tx_pkg.sv
// dw_8b10b_tx_pkg -- shared definitions for the 8b10b transmit sequencer.
//
// Holds the sequencer state encoding and the K-code byte values that the
// sequencer presents to the downstream 8b10b encoder (always with k_char=1).
// No ports; imported by dw_8b10b_tx_seq.

package dw_8b10b_tx_pkg;

  typedef enum logic [2:0] {
    ST_OFF,
    ST_INIT,
    ST_ALIGN,
    ST_IDLE,
    ST_SOP,
    ST_DATA,
    ST_EOP
  } state_t;

  localparam logic [7:0] K28_5 = 8'hBC;  // comma: alignment and idle fill
  localparam logic [7:0] K27_7 = 8'hFB;  // start of packet
  localparam logic [7:0] K29_7 = 8'hFD;  // end of packet
  localparam logic [7:0] K23_7 = 8'hF7;  // pad when the source has no byte
  localparam logic [7:0] K28_0 = 8'h1C;  // clock-compensation skip

endpackage

// File: rtl/dw_8b10b_tx_seq.sv
// dw_8b10b_tx_seq -- character sequencer in front of an 8b10b encoder.
//
// Brings the link up (running-disparity init, ALIGN_CNT commas), fills idle
// time with commas, and frames source packets as SOP, payload, EOP. Payload
// gaps are filled with pad characters. Every enc_* output and s_ready is a
// register: the character chosen from the state in cycle t shows in t+1.
//
// Parameters:
//   ALIGN_CNT     number of K28.5 sent after bring-up (1..255)
//   SKIP_INTERVAL characters between skip characters (4..65535)
//
// Optional feature macro: DW_8B10B_TX_SEQ_SKIP_EN
//   When defined, an idle K28.5 is replaced by K28.0 once SKIP_INTERVAL-1
//   enabled characters have been sent since the last skip. A skip falling
//   due inside a packet waits for the first idle cycle.
//
// Ports:
//   clk, rst_n        rising-edge clock, asynchronous active-low reset
//   link_en           1 requests link up, 0 requests link down
//   s_valid/s_ready   source byte handshake (transfer when both are 1)
//   s_data, s_last    payload byte and end-of-packet marker
//   enc_enable        encoder enable
//   enc_k_char        encoder k_char input
//   enc_data          encoder data_in input
//   enc_init_rd_n     encoder init_rd_n (active low, pulsed in INIT)
//   enc_init_rd_val   encoder init_rd_val (0 = negative disparity)
//   busy              state is SOP, DATA or EOP
//   pkt_cnt           completed packets, wraps
//   underrun_cnt      pad characters sent, saturates at 0xFF

module dw_8b10b_tx_seq
  import dw_8b10b_tx_pkg::*;
#(
  parameter int ALIGN_CNT     = 8,
  parameter int SKIP_INTERVAL = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        link_en,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [7:0]  s_data,
  input  logic        s_last,
  output logic        enc_enable,
  output logic        enc_k_char,
  output logic [7:0]  enc_data,
  output logic        enc_init_rd_n,
  output logic        enc_init_rd_val,
  output logic        busy,
  output logic [15:0] pkt_cnt,
  output logic [7:0]  underrun_cnt
);

  localparam logic [7:0] ALIGN_LAST = 8'(ALIGN_CNT - 1);

  // Reject out-of-range configurations at elaboration time.
  generate
    if (ALIGN_CNT < 1 || ALIGN_CNT > 255) begin : g_bad_align_cnt
      $error("dw_8b10b_tx_seq: ALIGN_CNT must be 1..255");
    end
    if (SKIP_INTERVAL < 4 || SKIP_INTERVAL > 65535) begin : g_bad_skip_interval
      $error("dw_8b10b_tx_seq: SKIP_INTERVAL must be 4..65535");
    end
  endgenerate

  state_t     state;
  state_t     next_state;
  logic [7:0] align_q;
  logic       en_d;
  logic       k_d;
  logic [7:0] data_d;
  logic       init_rd_n_d;
  logic       inc_pkt;
  logic       inc_underrun;
  logic       transfer;

`ifdef DW_8B10B_TX_SEQ_SKIP_EN
  localparam logic [15:0] SKIP_LAST = 16'(SKIP_INTERVAL - 1);
  logic [15:0] skip_cnt;
  logic        skip_due;
  logic        skip_take;

  // The counter parks at SKIP_LAST, so "due" stays set until an idle
  // cycle actually sends the skip.
  assign skip_due = (skip_cnt == SKIP_LAST);
`endif

  assign transfer = s_valid & s_ready;
  assign busy     = (state == ST_SOP) || (state == ST_DATA) || (state == ST_EOP);

  // Next state and the character for the current state.
  always_comb begin
    next_state   = state;
    en_d         = 1'b0;
    k_d          = 1'b0;
    data_d       = 8'h00;
    init_rd_n_d  = 1'b1;
    inc_pkt      = 1'b0;
    inc_underrun = 1'b0;
`ifdef DW_8B10B_TX_SEQ_SKIP_EN
    skip_take    = 1'b0;
`endif
    case (state)
      ST_OFF: begin
        if (link_en) next_state = ST_INIT;
      end
      ST_INIT: begin
        init_rd_n_d = 1'b0;
        next_state  = link_en ? ST_ALIGN : ST_OFF;
      end
      ST_ALIGN: begin
        en_d   = 1'b1;
        k_d    = 1'b1;
        data_d = K28_5;
        if (!link_en)                 next_state = ST_OFF;
        else if (align_q == ALIGN_LAST) next_state = ST_IDLE;
      end
      ST_IDLE: begin
        en_d   = 1'b1;
        k_d    = 1'b1;
        data_d = K28_5;
`ifdef DW_8B10B_TX_SEQ_SKIP_EN
        // The skip goes out even if this idle cycle is also leaving.
        if (skip_due) begin
          data_d    = K28_0;
          skip_take = 1'b1;
        end
`endif
        if (!link_en)     next_state = ST_OFF;
        else if (s_valid) next_state = ST_SOP;
      end
      ST_SOP: begin
        en_d       = 1'b1;
        k_d        = 1'b1;
        data_d     = K27_7;
        next_state = ST_DATA;
      end
      ST_DATA: begin
        en_d = 1'b1;
        if (transfer) begin
          data_d = s_data;
          if (s_last) next_state = ST_EOP;
        end else begin
          k_d          = 1'b1;
          data_d       = K23_7;
          inc_underrun = 1'b1;
        end
      end
      ST_EOP: begin
        en_d       = 1'b1;
        k_d        = 1'b1;
        data_d     = K29_7;
        inc_pkt    = 1'b1;
        next_state = link_en ? ST_IDLE : ST_OFF;
      end
      default: next_state = ST_OFF;
    endcase
  end

  // State and registered encoder-side outputs. s_ready is taken from the
  // next state so it is already high in the first DATA cycle and low in EOP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= ST_OFF;
      s_ready         <= 1'b0;
      enc_enable      <= 1'b0;
      enc_k_char      <= 1'b0;
      enc_data        <= 8'h00;
      enc_init_rd_n   <= 1'b1;
      enc_init_rd_val <= 1'b0;
    end else begin
      state           <= next_state;
      s_ready         <= (next_state == ST_DATA);
      enc_enable      <= en_d;
      enc_k_char      <= k_d;
      enc_data        <= data_d;
      enc_init_rd_n   <= init_rd_n_d;
      enc_init_rd_val <= 1'b0;
    end
  end

  // Alignment length counter and the status counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      align_q      <= 8'd0;
      pkt_cnt      <= 16'd0;
      underrun_cnt <= 8'd0;
    end else begin
      align_q <= (state == ST_ALIGN) ? align_q + 8'd1 : 8'd0;
      if (inc_pkt) pkt_cnt <= pkt_cnt + 16'd1;
      if (inc_underrun && underrun_cnt != 8'hFF) underrun_cnt <= underrun_cnt + 8'd1;
    end
  end

`ifdef DW_8B10B_TX_SEQ_SKIP_EN
  // Counts enabled characters since the last skip, holding once due.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skip_cnt <= 16'd0;
    end else if (skip_take) begin
      skip_cnt <= 16'd0;
    end else if (en_d && !skip_due) begin
      skip_cnt <= skip_cnt + 16'd1;
    end
  end
`endif

endmodule
